// File: rtl/traffic_intersection_ctrl_if.sv
// Purpose: lamp/command bundle between a supervisor and traffic_intersection_ctrl.
// Latency: none, wires only.
// Backpressure: none; enable and flash are level controls, lamps are continuous drives.
// Ports: enable, flash, ped_req (TL_PED_EN only) flow supervisor -> controller;
//        red, yellow, green, walk (TL_PED_EN only), phase_dir flow controller -> supervisor.
// master = supervisor side, slave = controller side.
interface traffic_intersection_ctrl_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = (NUM_DIR < 2) ? 1 : $clog2(NUM_DIR);

    logic               enable;
    logic               flash;
    logic [NUM_DIR-1:0] red;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] green;
    logic [DIR_W-1:0]   phase_dir;
`ifdef TL_PED_EN
    logic [NUM_DIR-1:0] ped_req;
    logic [NUM_DIR-1:0] walk;

    modport master (
        output enable, flash, ped_req,
        input  red, yellow, green, walk, phase_dir
    );
    modport slave (
        input  enable, flash, ped_req,
        output red, yellow, green, walk, phase_dir
    );
`else
    modport master (
        output enable, flash,
        input  red, yellow, green, phase_dir
    );
    modport slave (
        input  enable, flash,
        output red, yellow, green, phase_dir
    );
`endif
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Purpose: round-robin multi-approach signal controller (GREEN/YELLOW/ALL_RED) with flashing-yellow fault mode.
// Latency: lamps decode from registers only; any input change shows up one clock after the edge that samples it.
// Backpressure: enable=0 freezes all phase state (requests still latch); flash overrides enable.
// Ports: clk, reset (async active-low), tl (traffic_intersection_ctrl_if.slave):
//        enable, flash, ped_req in; red, yellow, green, walk, phase_dir out.
// Optional feature: define TL_PED_EN to add pedestrian request latching and walk lamps.
module traffic_intersection_ctrl #(
    parameter int NUM_DIR   = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_T   = 20,
    parameter int YELLOW_T  = 7,
    parameter int ALL_RED_T = 3,
    parameter int FLASH_T   = 16,
    parameter int PED_T     = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_intersection_ctrl_if.slave  tl
);
    localparam int DIR_W = (NUM_DIR < 2) ? 1 : $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);
    localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
        $error("traffic_intersection_ctrl: NUM_DIR must be 2..4");
    end
    if (PED_T > GREEN_T) begin : g_bad_ped_t
        $error("traffic_intersection_ctrl: PED_T must not exceed GREEN_T");
    end

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_FLASH   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flash_tog_q, flash_tog_d;
    logic [DIR_W-1:0]   next_dir;

    logic [NUM_DIR-1:0] red_c, yellow_c, green_c;

`ifdef TL_PED_EN
    localparam logic [CNT_W-1:0] PED_LIM = CNT_W'(PED_T);

    logic [NUM_DIR-1:0] ped_pend_q, ped_pend_d;
    logic [NUM_DIR-1:0] ped_clr;
    // Set on green entry when the served approach had a pending request.
    logic               walk_act_q, walk_act_d;
    logic [NUM_DIR-1:0] walk_c;
`endif

    assign next_dir = (cur_dir_q == LAST_DIR) ? '0 : cur_dir_q + DIR_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_ALL_RED;
            cur_dir_q   <= LAST_DIR;
            cnt_q       <= '0;
            flash_tog_q <= 1'b0;
`ifdef TL_PED_EN
            ped_pend_q  <= '0;
            walk_act_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            cnt_q       <= cnt_d;
            flash_tog_q <= flash_tog_d;
`ifdef TL_PED_EN
            ped_pend_q  <= ped_pend_d;
            walk_act_q  <= walk_act_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        cnt_d       = cnt_q;
        flash_tog_d = flash_tog_q;
`ifdef TL_PED_EN
        ped_clr     = '0;
        walk_act_d  = walk_act_q;
`endif

        if (tl.flash) begin
            if (state_q != S_FLASH) begin
                state_d     = S_FLASH;
                cnt_d       = '0;
                flash_tog_d = 1'b1;
            end else if (cnt_q == FLASH_LAST) begin
                flash_tog_d = ~flash_tog_q;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (tl.enable) begin
            case (state_q)
                S_ALL_RED: begin
                    if (cnt_q == AR_LAST) begin
                        state_d   = S_GREEN;
                        cur_dir_d = next_dir;
                        cnt_d     = '0;
`ifdef TL_PED_EN
                        walk_act_d        = ped_pend_q[next_dir];
                        ped_clr[next_dir] = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GREEN: begin
                    if (cnt_q == GREEN_LAST) begin
                        state_d = S_YELLOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (cnt_q == YELLOW_LAST) begin
                        state_d = S_ALL_RED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Leaving flash: clear the junction first; cur_dir is kept so
                // rotation resumes with the approach after the one interrupted.
                // With enable low the controller stays dark-flashing-frozen in FLASH.
                S_FLASH: begin
                    state_d = S_ALL_RED;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_ALL_RED;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef TL_PED_EN
        // Clear before set so a request coinciding with service stays pending.
        ped_pend_d = (ped_pend_q & ~ped_clr) | tl.ped_req;
`endif
    end

    // Lamp decode, registers only
    always_comb begin
        red_c    = '1;
        yellow_c = '0;
        green_c  = '0;
`ifdef TL_PED_EN
        walk_c   = '0;
`endif
        case (state_q)
            S_GREEN: begin
                red_c[cur_dir_q]   = 1'b0;
                green_c[cur_dir_q] = 1'b1;
`ifdef TL_PED_EN
                walk_c[cur_dir_q]  = walk_act_q && (cnt_q < PED_LIM);
`endif
            end
            S_YELLOW: begin
                red_c[cur_dir_q]    = 1'b0;
                yellow_c[cur_dir_q] = 1'b1;
            end
            S_FLASH: begin
                red_c    = '0;
                yellow_c = {NUM_DIR{flash_tog_q}};
            end
            default: begin
            end
        endcase
    end

    assign tl.red       = red_c;
    assign tl.yellow    = yellow_c;
    assign tl.green     = green_c;
    assign tl.phase_dir = cur_dir_q;
`ifdef TL_PED_EN
    assign tl.walk      = walk_c;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Purpose: directed, table-driven check of traffic_intersection_ctrl (NUM_DIR=3, G=5, Y=2, AR=1, FLASH=4, PED=3).
// Latency: each table row states the lamps seen in each of its cycles; its inputs apply to the edge ending that cycle.
// Backpressure: n/a.
module tb_traffic_intersection_ctrl;
    localparam int N = 3;

    logic clk;
    logic reset;

    traffic_intersection_ctrl_if #(.NUM_DIR(N)) tl ();

    traffic_intersection_ctrl #(
        .NUM_DIR   (N),
        .CNT_W     (8),
        .GREEN_T   (5),
        .YELLOW_T  (2),
        .ALL_RED_T (1),
        .FLASH_T   (4),
        .PED_T     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tl    (tl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       fl;
        logic [2:0] ped;
        int         n;
        logic [2:0] r;
        logic [2:0] y;
        logic [2:0] g;
        logic [2:0] w;
        logic [1:0] dir;
    } row_t;

    row_t rows[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic add(input logic en, input logic fl, input logic [2:0] ped, input int n,
                       input logic [2:0] r, input logic [2:0] y, input logic [2:0] g,
                       input logic [2:0] w, input logic [1:0] dir);
        row_t t;
        t.en = en; t.fl = fl; t.ped = ped; t.n = n;
        t.r = r; t.y = y; t.g = g; t.w = w; t.dir = dir;
        rows.push_back(t);
    endtask

    task automatic chk(input string nm, input int row, input int cyc,
                       input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d cyc=%0d got=%b want=%b", nm, row, cyc, act, exp);
        end
    endtask

    task automatic chk_lamps(input int row, input int cyc, input logic [2:0] r,
                             input logic [2:0] y, input logic [2:0] g,
                             input logic [2:0] w, input logic [1:0] dir);
        logic [2:0] nonred;
        chk("red",       row, cyc, {5'd0, tl.red},       {5'd0, r});
        chk("yellow",    row, cyc, {5'd0, tl.yellow},    {5'd0, y});
        chk("green",     row, cyc, {5'd0, tl.green},     {5'd0, g});
        chk("phase_dir", row, cyc, {6'd0, tl.phase_dir}, {6'd0, dir});
`ifdef TL_PED_EN
        chk("walk",      row, cyc, {5'd0, tl.walk},      {5'd0, w});
`else
        if (w != 3'b000) $display("note: walk expectation ignored without TL_PED_EN");
`endif
        // Safety invariants; flash mode deliberately lights every approach amber.
        if (r != 3'b000) begin
            nonred = ~tl.red;
            chk("one_nonred", row, cyc, {7'd0, $onehot0(nonred)}, 8'd1);
        end
        chk("no_g_and_y", row, cyc, {7'd0, (tl.green == 3'b000) || (tl.yellow == 3'b000)}, 8'd1);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int k = 0; k < rows[i].n; k++) begin
                chk_lamps(i, k, rows[i].r, rows[i].y, rows[i].g, rows[i].w, rows[i].dir);
                tl.enable = rows[i].en;
                tl.flash  = rows[i].fl;
`ifdef TL_PED_EN
                tl.ped_req = rows[i].ped;
`endif
                @(negedge clk);
                #1;
            end
        end
    endtask

    int seg1_end;
    int seg2_end;

    initial begin
        // Segment 1: rotation, enable freeze in green[1], flash during yellow[0].
        //    en fl ped  n  red     yellow  green   walk    dir
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 5,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 0, 3'b000, 2,  3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 2,  3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(0, 0, 3'b000, 10, 3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(1, 0, 3'b000, 3,  3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(1, 0, 3'b000, 2,  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 5,  3'b011, 3'b000, 3'b100, 3'b000, 2'd2);
        add(1, 0, 3'b000, 2,  3'b011, 3'b100, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 5,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 1, 3'b000, 1,  3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        add(1, 1, 3'b000, 4,  3'b000, 3'b111, 3'b000, 3'b000, 2'd0);
        add(1, 1, 3'b000, 4,  3'b000, 3'b000, 3'b000, 3'b000, 2'd0);
        add(1, 1, 3'b000, 1,  3'b000, 3'b111, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 1,  3'b000, 3'b111, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 5,  3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(1, 0, 3'b000, 1,  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        seg1_end = rows.size();
        // Segment 2: restart after mid-yellow reset, pedestrian request on approach 2.
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 1,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 0, 3'b100, 1,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 0, 3'b000, 3,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 0, 3'b000, 2,  3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 5,  3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(1, 0, 3'b000, 2,  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 3,  3'b011, 3'b000, 3'b100, 3'b100, 2'd2);
        add(1, 0, 3'b000, 2,  3'b011, 3'b000, 3'b100, 3'b000, 2'd2);
        add(1, 0, 3'b000, 2,  3'b011, 3'b100, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        add(1, 0, 3'b000, 5,  3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        add(1, 0, 3'b000, 2,  3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        add(1, 0, 3'b000, 5,  3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        add(1, 0, 3'b000, 2,  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000, 2'd1);
        add(1, 0, 3'b000, 5,  3'b011, 3'b000, 3'b100, 3'b000, 2'd2);
        seg2_end = rows.size();

        // Reset values, held across clock edges with inputs active.
        reset     = 1'b0;
        tl.enable = 1'b1;
        tl.flash  = 1'b0;
`ifdef TL_PED_EN
        tl.ped_req = '0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk_lamps(-1, 0, 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);

        reset = 1'b1;
        #1;
        run(0, seg1_end);

        // Now in the second yellow[1] cycle: async reset must act without a clock edge.
        chk("pre_rst_yellow", -2, 0, {5'd0, tl.yellow}, 8'b0000_0010);
        reset = 1'b0;
        #1;
        chk_lamps(-2, 1, 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        @(negedge clk);
        #1;
        chk_lamps(-2, 2, 3'b111, 3'b000, 3'b000, 3'b000, 2'd2);
        reset = 1'b1;
        #1;
        run(seg1_end, seg2_end);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
